// File: rtl/instr_sequencer_if.sv
// Fetch and execution-unit bus between the sequencer and its environment.
// master: sequencer side; slave: instruction memory / unit FSM side.
interface instr_sequencer_if;
    logic        instr_req;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] ir_out;
    logic [3:0]  unit_start;
    logic [3:0]  unit_grant;
    logic [3:0]  unit_done;

    modport master (
        output instr_req,
        output ir_out,
        output unit_start,
        output unit_grant,
        input  instr_valid,
        input  instr_data,
        input  unit_done
    );

    modport slave (
        input  instr_req,
        input  ir_out,
        input  unit_start,
        input  unit_grant,
        output instr_valid,
        output instr_data,
        output unit_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch, decode, dispatch to one of four unit FSMs, wait, retire.
// Ports: clk, rst (async active-low), run, err_clr, bus (fetch + unit bus), status outputs.
module instr_sequencer #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             err_clr,
    instr_sequencer_if.master bus,
    output logic             busy,
    output logic             halted,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_WAIT,
        S_RETIRE,
        S_HALT,
        S_ERROR
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [15:0]      timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             tmo_q, tmo_d;

    logic [3:0] unit_oh;
    logic       is_nop;
    logic       is_halt;
    logic       is_ill;
    logic       req;
    logic [3:0] start;
    logic [3:0] grant;

    // Decode straight from the latched word; ir_q is stable from DECODE
    // through WAIT, so the selected unit cannot change mid-execution.
    always_comb begin
        unit_oh = 4'b0000;
        is_nop  = 1'b0;
        is_halt = 1'b0;
        is_ill  = 1'b0;
        case (ir_q[15:12])
            4'h0:       is_nop  = 1'b1;
            4'h1, 4'h2: unit_oh = 4'b0001;
            4'h3, 4'h4: unit_oh = 4'b0010;
            4'h5:       unit_oh = 4'b0100;
            4'h6:       unit_oh = 4'b1000;
            4'hF:       is_halt = 1'b1;
            default:    is_ill  = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        tmo_d   = tmo_q;
        req     = 1'b0;
        start   = 4'b0000;
        grant   = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                req = 1'b1;
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_nop) begin
                    state_d = S_RETIRE;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_ill) begin
                    state_d = S_ERROR;
                    ill_d   = 1'b1;
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                start   = unit_oh;
                grant   = unit_oh;
                timer_d = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                grant   = unit_oh;
                timer_d = timer_q + 16'd1;
                // Only the granted unit's done counts; done beats timeout.
                if (|(bus.unit_done & unit_oh)) begin
                    state_d = S_RETIRE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_ERROR;
                    tmo_d   = 1'b1;
                end
            end
            S_RETIRE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERROR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                    ill_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
            timer_q <= 16'd0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.instr_req  = req;
    assign bus.ir_out     = ir_q;
    assign bus.unit_start = start;
    assign bus.unit_grant = grant;

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT)
                      && (state_q != S_ERROR);
    assign halted      = (state_q == S_HALT);
    assign err_illegal = ill_q;
    assign err_timeout = tmo_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_instr_sequencer;

    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 8;
    localparam int CMOD    = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             err_clr;
    logic             busy;
    logic             halted;
    logic             err_illegal;
    logic             err_timeout;
    logic [CNT_W-1:0] instr_count;

    instr_sequencer_if bus();

    instr_sequencer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .err_clr    (err_clr),
        .bus        (bus),
        .busy       (busy),
        .halted     (halted),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -1 NOP, 0..3 unit index, 4 HALT, 5 illegal
    function automatic int unit_of(input logic [15:0] w);
        case (w[15:12])
            4'h0:       return -1;
            4'h1, 4'h2: return 0;
            4'h3, 4'h4: return 1;
            4'h5:       return 2;
            4'h6:       return 3;
            4'hF:       return 4;
            default:    return 5;
        endcase
    endfunction

    // Model: does this instruction end in the error state?
    function automatic bit ends_in_error(input logic [15:0] w, input int d);
        int u;
        u = unit_of(w);
        return (u == 5) || (u >= 0 && u < 4 && d >= TIMEOUT);
    endfunction

    task automatic fetch(input logic [15:0] w, input int wt);
        int n;
        n = 0;
        while (bus.instr_req !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", 32'(bus.instr_req), 32'd1);
        for (int i = 0; i < wt; i++) begin
            bus.instr_valid = 1'b0;
            @(negedge clk);
            chk("fetch_hold", 32'(bus.instr_req), 32'd1);
        end
        bus.instr_valid = 1'b1;
        bus.instr_data  = w;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'($urandom);
        chk("decode_ir", 32'(bus.ir_out), 32'(w));
        chk("decode_start", 32'(bus.unit_start), 32'd0);
    endtask

    // d: WAIT-cycle index (0 = first cycle after dispatch) at which the
    // granted unit pulses done; d >= TIMEOUT means it never does.
    task automatic exec(input logic [15:0] w, input int wt, input int d);
        int         u;
        int         gcyc;
        logic [3:0] oh;
        u = unit_of(w);
        fetch(w, wt);
        @(negedge clk);
        if (u < 0) begin
            chk("nop_grant", 32'(bus.unit_grant), 32'd0);
            chk("nop_cnt_hold", 32'(instr_count), 32'(exp_count));
            @(negedge clk);
            exp_count = (exp_count + 1) % CMOD;
            chk("nop_cnt", 32'(instr_count), 32'(exp_count));
        end else if (u < 4) begin
            oh = 4'b0001 << u;
            gcyc = (bus.unit_grant === oh) ? 1 : 0;
            chk("disp_start", 32'(bus.unit_start), 32'(oh));
            chk("disp_grant", 32'(bus.unit_grant), 32'(oh));
            for (int c = 0; c < TIMEOUT; c++) begin
                @(negedge clk);
                chk("wait_start", 32'(bus.unit_start), 32'd0);
                chk("wait_ir", 32'(bus.ir_out), 32'(w));
                if (bus.unit_grant === oh) gcyc++;
                if (c == d) begin
                    bus.unit_done = oh | (4'($urandom) & ~oh);
                    break;
                end
                bus.unit_done = 4'($urandom) & ~oh;
            end
            @(negedge clk);
            bus.unit_done = 4'b0000;
            chk("grant_cycles", 32'(gcyc),
                32'((d < TIMEOUT) ? d + 2 : TIMEOUT + 1));
            chk("post_grant", 32'(bus.unit_grant), 32'd0);
            if (d < TIMEOUT) begin
                chk("retire_busy", 32'(busy), 32'd1);
                chk("retire_cnt_hold", 32'(instr_count), 32'(exp_count));
                @(negedge clk);
                exp_count = (exp_count + 1) % CMOD;
                chk("retire_cnt", 32'(instr_count), 32'(exp_count));
            end else begin
                chk("tmo_flag", 32'(err_timeout), 32'd1);
                chk("tmo_busy", 32'(busy), 32'd0);
                chk("tmo_cnt", 32'(instr_count), 32'(exp_count));
            end
        end else if (u == 4) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_busy", 32'(busy), 32'd0);
            chk("halt_req", 32'(bus.instr_req), 32'd0);
        end else begin
            chk("ill_flag", 32'(err_illegal), 32'd1);
            chk("ill_start", 32'(bus.unit_start), 32'd0);
            chk("ill_busy", 32'(busy), 32'd0);
            chk("ill_cnt", 32'(instr_count), 32'(exp_count));
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_ill", 32'(err_illegal), 32'd0);
        chk("clr_tmo", 32'(err_timeout), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        logic [15:0] w;
        int wt;
        int d;

        rst = 1'b0;
        run = 1'b0;
        err_clr = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;
        bus.unit_done   = 4'b0000;
        #1;
        chk("rst_req", 32'(bus.instr_req), 32'd0);
        chk("rst_ir", 32'(bus.ir_out), 32'd0);
        chk("rst_start", 32'(bus.unit_start), 32'd0);
        chk("rst_grant", 32'(bus.unit_grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        chk("rst_errs", 32'({err_illegal, err_timeout}), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;

        // NOP stream with zero-wait memory: one retire every 3 cycles
        run = 1'b1;
        last = -1;
        for (int i = 0; i < 5; i++) begin
            exec(16'h0000, 0, 0);
            if (last >= 0) chk("nop_period", 32'(cyc - last), 32'd3);
            last = cyc;
        end

        // ALUI, done 9 cycles after start -> 10 grant cycles
        exec(16'h1045, 0, 8);
        // LOAD with stray done pulses from other units
        exec(16'h5000, 1, 5);
        // Done on the very last permitted WAIT cycle still retires
        exec(16'h6123, 2, TIMEOUT - 1);
        // ALU that never finishes -> timeout
        exec(16'h3000, 0, 1000);
        run = 1'b0;
        clear_err();
        @(negedge clk);
        chk("idle_req", 32'(bus.instr_req), 32'd0);

        // Illegal opcode
        run = 1'b1;
        exec(16'h9ABC, 0, 0);
        clear_err();

        // run dropped during a fetch: fetch completes, then idle
        exec(16'h0000, 0, 0);
        run = 1'b0;
        exec(16'h0000, 1, 0);
        chk("stop_req", 32'(bus.instr_req), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("stop_req2", 32'(bus.instr_req), 32'd0);
        run = 1'b1;

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            w  = {4'($urandom_range(0, 14)), 12'($urandom)};
            wt = $urandom_range(0, 3);
            d  = ($urandom_range(0, 9) == 0) ? TIMEOUT + 5
                                             : $urandom_range(0, 12);
            exec(w, wt, d);
            if (ends_in_error(w, d)) clear_err();
        end

        // HALT is terminal: run and err_clr are ignored
        exec(16'hF000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            err_clr = i[0];
            @(negedge clk);
            chk("halt_hold", 32'({halted, busy, bus.instr_req}), 32'b100);
        end
        err_clr = 1'b0;

        // Reset in the middle of WAIT drops the grant asynchronously
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;
        fetch(16'h2001, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_grant", 32'(bus.unit_grant), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.unit_grant), 32'd0);
        chk("arst_start", 32'(bus.unit_start), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cnt", 32'(instr_count), 32'd0);
        chk("arst_ir", 32'(bus.ir_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Counter wraps after 2^CNT_W retires
        for (int i = 0; i < CMOD; i++) exec(16'h0000, 0, 0);
        chk("wrap", 32'(instr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
